// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the spi_master initiator.
//   FRAME_BITS / ADDR_BITS / DATA_BITS : frame geometry (16 = 7 addr + rw + 8 data)
//   RW_READ / RW_WRITE                 : encoding of the rw bit in the address byte
//   spi_state_e                        : initiator phase encoding
//   build_frame()                      : packs one outgoing frame, MSB first
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int   FRAME_BITS = 16;
    localparam int   ADDR_BITS  = 7;
    localparam int   DATA_BITS  = 8;
    localparam int   BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam logic RW_READ    = 1'b1;
    localparam logic RW_WRITE   = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4
    } spi_state_e;

    // A read carries a zero data byte so the responder sees a clean 0x00.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [ADDR_BITS-1:0] addr,
        input logic                 rw,
        input logic [DATA_BITS-1:0] wdata
    );
        logic [DATA_BITS-1:0] data_byte;
        data_byte = (rw == RW_READ) ? '0 : wdata;
        return {addr, rw, data_byte};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// Phase-length divider shared by every SPI phase. Loading sets the counter to
// CLK_DIV-1; it then counts down and holds at zero. tc_o is high in the last
// clk cycle of a phase, so a phase lasts exactly CLK_DIV cycles from its load.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   load_i   in   reload the counter (asserted on every phase entry)
//   tc_o     out  terminal count: current cycle is the last one of the phase
// -----------------------------------------------------------------------------
module spi_sclk_gen #(
    parameter int CLK_DIV = 5,
    parameter int DIV_W   = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    output logic tc_o
);

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = RELOAD;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Mode-0 SPI initiator issuing one 16-bit frame per command:
// {addr[6:0], rw} then a data byte, MSB first. Every pin is driven straight
// from a flop, so sclk_pin is glitch free.
//
// Build option: define SPI_MISO_SYNC_EN to route miso_pin through a two-flop
// synchronizer; the sample point then moves to 2 clk cycles after sclk rises
// (needs CLK_DIV >= 3). Frame timing is identical in both builds.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset (aborts any frame at once)
//   start     in   command request, sampled only in IDLE
//   addr      in   7-bit memory address
//   rw        in   1 = read, 0 = write
//   wdata     in   write data byte (ignored on reads)
//   busy      out  frame in progress
//   done      out  one-cycle pulse when cs_pin returns high
//   rdata     out  last read byte, held until the next read completes
//   sclk_pin  out  SPI clock, idle low
//   cs_pin    out  chip select, active low
//   mosi_pin  out  serial data out, changes only while sclk_pin is low
//   miso_pin  in   serial data in
// -----------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 5,
    parameter int DIV_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 rw,
    input  logic [DATA_BITS-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 sclk_pin,
    output logic                 cs_pin,
    output logic                 mosi_pin,
    input  logic                 miso_pin
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    spi_state_e                state_q, state_d;
    logic [FRAME_BITS-1:0]     shift_q, shift_d;
    logic [DATA_BITS-1:0]      rx_q, rx_d;
    logic [DATA_BITS-1:0]      rdata_q, rdata_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                      sclk_q, sclk_d;
    logic                      cs_q, cs_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      rw_q, rw_d;

    logic                      div_tc;
    logic                      phase_end;
    logic                      high_entry;
    logic                      sample_en;
    logic                      miso_bit;

    // A phase ends on terminal count; IDLE ends on an accepted start. Every
    // phase end is a state entry, so it doubles as the divider reload.
    assign phase_end  = (state_q == IDLE) ? start : div_tc;
    assign high_entry = div_tc && ((state_q == SETUP) || (state_q == LOW));

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_sclk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (phase_end),
        .tc_o    (div_tc)
    );

`ifdef SPI_MISO_SYNC_EN
    logic [1:0] miso_sync_q;
    logic [1:0] sample_q;

    // sample_q delays the HIGH-entry strobe to line up with the
    // synchronizer latency: sampling lands 2 clk cycles after sclk rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_sync_q <= '0;
            sample_q    <= '0;
        end else begin
            miso_sync_q <= {miso_sync_q[0], miso_pin};
            sample_q    <= {sample_q[0], high_entry};
        end
    end

    assign sample_en = sample_q[1];
    assign miso_bit  = miso_sync_q[1];
`else
    assign sample_en = high_entry;
    assign miso_bit  = miso_pin;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rw_d      = rw_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = build_frame(addr, rw, wdata);
                    rw_d      = rw;
                    bit_cnt_d = '0;
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (div_tc) begin
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (div_tc) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        // mosi_pin is the shift register MSB, so shifting
                        // here presents the next bit as sclk falls.
                        shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        state_d   = LOW;
                    end
                end
            end
            LOW: begin
                if (div_tc) begin
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HOLD: begin
                if (div_tc) begin
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (rw_q == RW_READ) begin
                        rdata_d = rx_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Only the last 8 samples matter: they are the data-byte phases.
        if (sample_en) begin
            rx_d = {rx_q[DATA_BITS-2:0], miso_bit};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rw_q      <= RW_WRITE;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rw_q      <= rw_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign sclk_pin = sclk_q;
    assign cs_pin   = cs_q;
    assign mosi_pin = shift_q[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Two initiators share clk/reset: instance 0 at CLK_DIV=5, instance 1 at the
// smallest divider legal for the build (2, or 3 with SPI_MISO_SYNC_EN).
// A behavioural spiMemory responder per instance captures mosi on sclk rises,
// measures frame timing and serves reads from its own memory (or an override
// byte). Expected results go into a scoreboard queue when a command is issued
// and are popped when done pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master;

    localparam int N_DUT = 2;
`ifdef SPI_MISO_SYNC_EN
    localparam int FAST_DIV = 3;
`else
    localparam int FAST_DIV = 2;
`endif
    localparam int DONE_BUDGET = 5000;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic             reset_n;
    logic [N_DUT-1:0] start_s, rw_s, busy_s, done_s, sclk_s, cs_s, mosi_s;
    logic [6:0]       addr_s  [N_DUT];
    logic [7:0]       wdata_s [N_DUT];
    logic [7:0]       rdata_s [N_DUT];

    // responder state, written only by the responder process
    logic [N_DUT-1:0] sclk_prev, cs_prev, is_read, resp_miso;
    logic [15:0]      sh_q [N_DUT];
    logic [7:0]       out_byte [N_DUT];
    logic [7:0]       mem [N_DUT][128];
    int               bit_q [N_DUT], pulse_q [N_DUT], cs_cyc_q [N_DUT], hi_cyc_q [N_DUT];
    int               since_q [N_DUT], per_min_q [N_DUT], per_max_q [N_DUT];
    logic [15:0]      last_word [N_DUT];
    int               last_pulses [N_DUT], last_cs_cyc [N_DUT], last_gap [N_DUT];
    int               last_per_min [N_DUT], last_per_max [N_DUT], done_cnt [N_DUT];

    // responder read override, driven by the stimulus
    logic [N_DUT-1:0] ovr_en;
    logic [7:0]       ovr_val [N_DUT];

    typedef struct {
        logic [15:0] mosi;
        logic [7:0]  rdata;
    } exp_t;
    exp_t sb [$];

    int checks = 0;
    int errors = 0;

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        spi_master #(
            .CLK_DIV ((gi == 0) ? 5 : FAST_DIV),
            .DIV_W   (8)
        ) u_dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .start    (start_s[gi]),
            .addr     (addr_s[gi]),
            .rw       (rw_s[gi]),
            .wdata    (wdata_s[gi]),
            .busy     (busy_s[gi]),
            .done     (done_s[gi]),
            .rdata    (rdata_s[gi]),
            .sclk_pin (sclk_s[gi]),
            .cs_pin   (cs_s[gi]),
            .mosi_pin (mosi_s[gi]),
            .miso_pin (resp_miso[gi])
        );
    end

    // Behavioural spiMemory, observed on the falling clk edge.
    always @(negedge clk) begin
        for (int i = 0; i < N_DUT; i++) begin
            logic [15:0] sh;
            int          nb;
            sh = {sh_q[i][14:0], mosi_s[i]};
            nb = bit_q[i] + 1;
            sclk_prev[i] <= sclk_s[i];
            cs_prev[i]   <= cs_s[i];
            if (done_s[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (cs_prev[i] && !cs_s[i]) begin
                sh_q[i]      <= '0;
                bit_q[i]     <= 0;
                pulse_q[i]   <= 0;
                cs_cyc_q[i]  <= 1;
                since_q[i]   <= 0;
                per_min_q[i] <= 1000000;
                per_max_q[i] <= 0;
                is_read[i]   <= 1'b0;
                resp_miso[i] <= 1'b0;
                last_gap[i]  <= hi_cyc_q[i];
            end else if (!cs_s[i]) begin
                cs_cyc_q[i] <= cs_cyc_q[i] + 1;
                since_q[i]  <= since_q[i] + 1;
                if (sclk_s[i] && !sclk_prev[i]) begin
                    sh_q[i]    <= sh;
                    bit_q[i]   <= nb;
                    pulse_q[i] <= pulse_q[i] + 1;
                    since_q[i] <= 0;
                    if (pulse_q[i] > 0) begin
                        if (since_q[i] + 1 < per_min_q[i]) per_min_q[i] <= since_q[i] + 1;
                        if (since_q[i] + 1 > per_max_q[i]) per_max_q[i] <= since_q[i] + 1;
                    end
                    if (nb == 8) begin
                        is_read[i]  <= sh[0];
                        out_byte[i] <= ovr_en[i] ? ovr_val[i] : mem[i][sh[7:1]];
                    end
                    if (nb == 16 && !is_read[i]) mem[i][sh[15:9]] <= sh[7:0];
                end else if (!sclk_s[i] && sclk_prev[i]) begin
                    if (is_read[i] && bit_q[i] >= 8 && bit_q[i] < 16)
                        resp_miso[i] <= out_byte[i][15 - bit_q[i]];
                    else
                        resp_miso[i] <= 1'b0;
                end
            end else begin
                hi_cyc_q[i] <= cs_prev[i] ? hi_cyc_q[i] + 1 : 1;
                if (!cs_prev[i]) begin
                    last_word[i]    <= sh_q[i];
                    last_pulses[i]  <= pulse_q[i];
                    last_cs_cyc[i]  <= cs_cyc_q[i];
                    last_per_min[i] <= per_min_q[i];
                    last_per_max[i] <= per_max_q[i];
                end
            end
        end
    end

    function automatic int div_of(input int inst);
        return (inst == 0) ? 5 : FAST_DIV;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [6:0] a, input logic r, input logic [7:0] wd,
                            input logic [7:0] exp_rd);
        exp_t e;
        e.mosi  = {a, r, (r ? 8'h00 : wd)};
        e.rdata = exp_rd;
        sb.push_back(e);
    endtask

    task automatic launch(input int inst, input logic [6:0] a, input logic r,
                          input logic [7:0] wd, input bit hold);
        @(posedge clk); #1;
        addr_s[inst]  = a;
        rw_s[inst]    = r;
        wdata_s[inst] = wd;
        start_s[inst] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_s[inst] = 1'b0;
        chk("busy_after_start", 32'(busy_s[inst]), 32'd1);
        chk("cs_after_start", 32'(cs_s[inst]), 32'd0);
        $display("tx inst=%0d addr=0x%02h rw=%0d wdata=0x%02h", inst, a, r, wd);
    endtask

    task automatic finish_frame(input int inst, input bit cs_low_next);
        exp_t e;
        bit   ok;
        int   d;
        d  = div_of(inst);
        ok = 1'b0;
        for (int c = 0; c < DONE_BUDGET; c++) begin
            @(negedge clk);
            if (done_s[inst]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(ok), 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("rdata", 32'(rdata_s[inst]), 32'(e.rdata));
            chk("busy_at_done", 32'(busy_s[inst]), 32'd0);
            chk("cs_at_done", 32'(cs_s[inst]), 32'd1);
            @(negedge clk);
            chk("done_width", 32'(done_s[inst]), 32'd0);
            chk("cs_next", 32'(cs_s[inst]), cs_low_next ? 32'd0 : 32'd1);
            chk("mosi_word", 32'(last_word[inst]), 32'(e.mosi));
            chk("sclk_pulses", 32'(last_pulses[inst]), 32'd16);
            chk("cs_low_cycles", 32'(last_cs_cyc[inst]), 32'(33 * d));
            chk("sclk_period_min", 32'(last_per_min[inst]), 32'(2 * d));
            chk("sclk_period_max", 32'(last_per_max[inst]), 32'(2 * d));
            $display("rx inst=%0d mosi=0x%04h rdata=0x%02h cs_low=%0d cycles",
                     inst, last_word[inst], rdata_s[inst], last_cs_cyc[inst]);
        end
    endtask

    task automatic wait_pulses(input int inst, input int n);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < DONE_BUDGET; c++) begin
            @(negedge clk);
            if (pulse_q[inst] == n && !cs_s[inst]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("pulse_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        int d0;
        reset_n = 1'b0;
        start_s = '0;
        rw_s    = '0;
        ovr_en  = '0;
        for (int i = 0; i < N_DUT; i++) begin
            addr_s[i]   = '0;
            wdata_s[i]  = '0;
            ovr_val[i]  = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < N_DUT; i++) begin
            chk("rst_cs", 32'(cs_s[i]), 32'd1);
            chk("rst_sclk", 32'(sclk_s[i]), 32'd0);
            chk("rst_mosi", 32'(mosi_s[i]), 32'd0);
            chk("rst_busy", 32'(busy_s[i]), 32'd0);
            chk("rst_done", 32'(done_s[i]), 32'd0);
            chk("rst_rdata", 32'(rdata_s[i]), 32'd0);
        end
        reset_n = 1'b1;
        $display("reset released");

        // Reset mid-frame during the 5th HIGH phase: abort is immediate
        launch(0, 7'h55, 1'b1, 8'h00, 1'b0);
        wait_pulses(0, 5);
        chk("pre_abort_sclk", 32'(sclk_s[0]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_cs", 32'(cs_s[0]), 32'd1);
        chk("abort_sclk", 32'(sclk_s[0]), 32'd0);
        chk("abort_busy", 32'(busy_s[0]), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        $display("mid-frame reset released");

        // Write at CLK_DIV=5: mosi 1000_1000_1011_1011, rdata untouched
        push_exp(7'h44, 1'b0, 8'hBB, 8'h00);
        launch(0, 7'h44, 1'b0, 8'hBB, 1'b0);
        finish_frame(0, 1'b0);

        // Read of 0x44 with the responder returning 0xA5
        ovr_en[0]  = 1'b1;
        ovr_val[0] = 8'hA5;
        push_exp(7'h44, 1'b1, 8'hFF, 8'hA5);
        launch(0, 7'h44, 1'b1, 8'hFF, 1'b0);
        finish_frame(0, 1'b0);
        ovr_en[0] = 1'b0;

        // Read-after-write through the memory model
        push_exp(7'h12, 1'b0, 8'h5C, 8'hA5);
        launch(0, 7'h12, 1'b0, 8'h5C, 1'b0);
        finish_frame(0, 1'b0);
        push_exp(7'h12, 1'b1, 8'h00, 8'h5C);
        launch(0, 7'h12, 1'b1, 8'h00, 1'b0);
        finish_frame(0, 1'b0);

        // start pulsed during bit 7 is ignored
        d0 = done_cnt[0];
        push_exp(7'h33, 1'b0, 8'h0F, 8'h5C);
        launch(0, 7'h33, 1'b0, 8'h0F, 1'b0);
        wait_pulses(0, 7);
        @(posedge clk); #1;
        addr_s[0] = 7'h7F; rw_s[0] = 1'b1; start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0; addr_s[0] = 7'h33; rw_s[0] = 1'b0;
        finish_frame(0, 1'b0);
        repeat (100) @(negedge clk);
        chk("busy_single_done", 32'(done_cnt[0]), 32'(d0 + 1));
        chk("busy_idle_cs", 32'(cs_s[0]), 32'd1);

        // start held high: two frames with a one-cycle cs-high gap
        push_exp(7'h21, 1'b0, 8'h96, 8'h5C);
        push_exp(7'h21, 1'b0, 8'h96, 8'h5C);
        launch(0, 7'h21, 1'b0, 8'h96, 1'b1);
        finish_frame(0, 1'b1);
        start_s[0] = 1'b0;
        finish_frame(0, 1'b0);
        chk("b2b_cs_gap", 32'(last_gap[0]), 32'd1);

        // Smallest divider: write 0x3C then read it back
        push_exp(7'h2A, 1'b0, 8'h3C, 8'h00);
        launch(1, 7'h2A, 1'b0, 8'h3C, 1'b0);
        finish_frame(1, 1'b0);
        push_exp(7'h2A, 1'b1, 8'h00, 8'h3C);
        launch(1, 7'h2A, 1'b1, 8'h00, 1'b0);
        finish_frame(1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
